// File: rtl/piso_tx_arbiter.sv
// Round-robin front end that shares one LSB-first PISO shift register between two requesters,
// pacing one serial bit every DIV clocks and framing each word for the downstream link.

module ShiftReg_PISO_Right #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic [W-1:0] d,
   input  logic         load,
   input  logic         enable,
   output logic         ser_out
);

   logic [W-1:0] q;

   always_ff @(posedge clk) begin
      if (load)
         q <= d;
      else if (enable)
         q <= {1'b0, q[W-1:1]};
   end

   assign ser_out = q[0];

endmodule

module piso_tx_arbiter #(
   parameter int W   = 8,
   parameter int DIV = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   input  logic [W-1:0] req0_data,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [W-1:0] req1_data,
   output logic         req1_ready,
   output logic [W-1:0] sr_d,
   output logic         sr_load,
   output logic         sr_enable,
   output logic         frame,
   output logic         grant,
   output logic         busy
);

   localparam int BW = $clog2(W);
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t        state, state_next;
   logic [BW-1:0] bit_cnt;
   logic [DW-1:0] div_cnt;
   logic          prio;
   logic          grant_q;
   logic          any_valid;
   logic          winner;
   logic          div_wrap;

   always_comb begin
      any_valid = req0_valid | req1_valid;
      winner    = (req0_valid & req1_valid) ? prio : req1_valid;
      div_wrap  = (div_cnt == DIV_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // The last bit is held for a full DIV period without a trailing enable.
   always_comb begin
      state_next = state;
      sr_load    = 1'b0;
      sr_enable  = 1'b0;
      sr_d       = '0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      frame      = 1'b0;
      case (state)
         IDLE: begin
            if (any_valid)
               state_next = LOAD;
         end
         LOAD: begin
            sr_load    = 1'b1;
            sr_d       = grant_q ? req1_data : req0_data;
            req0_ready = ~grant_q;
            req1_ready = grant_q;
            state_next = SHIFT;
         end
         SHIFT: begin
            frame = 1'b1;
            if (div_wrap) begin
               if (bit_cnt == BIT_LAST)
                  state_next = GAP;
               else
                  sr_enable = 1'b1;
            end
         end
         GAP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy  = (state != IDLE);
   assign grant = grant_q;

   // Arbitration is decided once per frame in IDLE; counters restart on every LOAD.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
         div_cnt <= '0;
         prio    <= 1'b0;
         grant_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  grant_q <= winner;
                  prio    <= ~winner;
               end
            end
            LOAD: begin
               bit_cnt <= '0;
               div_cnt <= '0;
            end
            SHIFT: begin
               if (div_wrap) begin
                  div_cnt <= '0;
                  if (bit_cnt != BIT_LAST)
                     bit_cnt <= bit_cnt + BW'(1);
               end else begin
                  div_cnt <= div_cnt + DW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Two-requester round-robin controller that shares one right-shifting parallel-in/serial-out shift register (ShiftReg_PISO_Right, LSB first) as a serial transmitter. It accepts a W-bit word from the granted requester and drives the register's `d`/`load`/`enable` pins. It paces bits at one per DIV clocks and frames each word with a `frame` strobe for the downstream serial consumer (display/LED link).

## Interface
- `W`, 8: word width; bits per frame; W ≥ 2
- `DIV`, 4: clocks per serial bit; DIV ≥ 1
- `clk`  in  1  system clock; all state changes on posedge
- `reset`  in  1  synchronous, active-high; one clock; sampled on posedge clk
- `req0_valid`  in  1  requester 0 has a word
- `req0_data`  in  W  requester 0 word
- `req0_ready`  out  1  one-cycle accept pulse to requester 0
- `req1_valid`  in  1  requester 1 has a word
- `req1_data`  in  W  requester 1 word
- `req1_ready`  out  1  one-cycle accept pulse to requester 1
- `sr_d`  out  W  to shift register `d`
- `sr_load`  out  1  to shift register `load`
- `sr_enable`  out  1  to shift register `enable`
- `frame`  out  1  high while ser_out carries a valid bit of the current word
- `grant`  out  1  index of requester owning current or last frame
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, LOAD, SHIFT, GAP; registered; reset → IDLE.
- IDLE: if any valid, pick winner, register `grant`, go LOAD; else stay.
- Arbitration: round-robin pointer `prio`. If only one valid, it wins. If both valid, `prio` wins. After each grant, `prio` ← other requester. Reset sets `prio` = 0 and `grant` = 0.
- LOAD (exactly 1 cycle): `sr_load`=1, `sr_d` = granted requester's data, `reqN_ready`=1 for granted N only → SHIFT; bit counter and divider cleared.
- SHIFT: `frame`=1. Divider counts 0..DIV-1 and wraps. On divider = DIV-1:
  - bit counter < W-1 → `sr_enable`=1 for that cycle, bit counter +1.
  - bit counter = W-1 → go GAP, no enable.
- Exactly W-1 enable pulses per frame; the W-th bit is held for DIV cycles and never shifted out.
- GAP (exactly 1 cycle): all strobes 0 → IDLE. Guarantees ≥2 frame-low cycles between frames.
- Requester rules:
  - Hold `valid` and `data` stable from assertion until the `ready` pulse.
  - `valid` dropped before `ready` is a protocol violation; the bench does not generate it.
  - Valids are sampled only in IDLE; requests arriving mid-frame wait.
- Outside LOAD: `sr_d` = 0, both ready = 0.
- Counters: bit counter ⌈log2 W⌉ bits; divider ⌈log2 DIV⌉ bits, min 1. No overflow: both are reset in LOAD.
- Reset mid-operation: state → IDLE and all counters cleared next edge. `frame`, `sr_load`, `sr_enable`, ready and `busy` are 0 in the cycle after reset is sampled. Shift register content is left as is (don't-care). No ready is issued for the aborted word.

## Timing
- Reset values: `sr_d`=0, `sr_load`=0, `sr_enable`=0, both ready=0, `frame`=0, `busy`=0, `grant`=0.
- All outputs decode from registered state/counters only; no combinational path from valid to any output.
- Cycle numbering: t = IDLE cycle in which valid is seen.
  - t+1: LOAD, `sr_load`, ready.
  - t+2 … t+1+W·DIV: SHIFT, `frame`=1; ser_out = bit k during t+2+k·DIV … t+1+(k+1)·DIV.
  - `sr_enable` high at t+1+k·DIV, k = 1…W-1.
  - t+2+W·DIV: GAP.
  - t+3+W·DIV: IDLE; next LOAD earliest at t+4+W·DIV.
- Frame period under continuous demand: W·DIV + 3 cycles.
- DIV=1: `sr_enable` high on every SHIFT cycle except the last.

## Test plan
Bench instantiates ShiftReg_PISO_Right. Defaults W=8, DIV=4 unless stated.
- Reset then idle: reset held 3 cycles, no valids, 20 cycles → all outputs 0; `busy`=0 throughout.
- Single word: req0 sends 8'b10110000 at t → `req0_ready` and `sr_load` at t+1; `frame` high t+2…t+33. ser_out, 4 cycles per bit, LSB first: 0,0,0,0,1,1,0,1. Exactly 7 `sr_enable` pulses, at t+5, t+9, …, t+29.
- Contention: both valid continuously, req0 0xA5, req1 0x3C → grants alternate 0,1,0,1. LOAD cycles 35 apart. Serialized words 0xA5, 0x3C, 0xA5, 0x3C.
- Late arrival: req1 asserts mid-frame of a req0 word → req1 gets no ready until the next IDLE. Its LOAD is exactly 3 cycles after the previous frame's last high cycle.
- Reset mid-frame: reset at bit 4 of a frame → `frame`/`busy` 0 the next cycle, no further enables; `prio` = 0, so with both valid afterward, req0 is granted first.
- DIV=1, W=2: word 2'b10 → `frame` 2 cycles, one `sr_enable` in the first SHIFT cycle, ser_out 0 then 1.
